mc_datapath_hs: RTL and testbench
=================================

// Module: mc_datapath_hs
// PURPOSE
//  Parametrised multicycle MIPS-style datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU.
//  Replaces the fixed 32-bit datapath's combinational memory with a req/ack bus, so memory may stall.
//  Adds conditional PC write (beq/bne) and an ALU overflow flag.
//  Driven by the multicycle controller; the controller waits on mem_done before leaving memory states.
// PARAMETERS
//  XLEN      32   datapath width; legal values are 32 and 64; instruction fields always come from IR[31:0]
//  NREG      32   register count (power of 2, 2..32); regfile address width RA=$clog2(NREG)
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous reset, active-low
//  pc_write    in   1     unconditional PC load
//  pc_write_c  in   1     conditional PC load: taken when (zero ^ branch_ne)
//  branch_ne   in   1     invert the branch condition (bne)
//  IR_write    in   1     load IR from the completed fetch
//  reg_dst     in   1     write-register select: 0=IR[20:16], 1=IR[15:11]
//  jal_reg     in   1     force write-register to 31 (NREG-1 if NREG<32)
//  mem_to_reg  in   1     write-data select: 0=ALUOut, 1=MDR
//  pc_to_reg   in   1     write data = PC; overrides mem_to_reg
//  reg_write   in   1     regfile write enable
//  alu_src_A   in   1     ALU A select: 0=PC, 1=A
//  alu_src_B   in   2     ALU B select: 0=B, 1=4, 2=sext(imm), 3=sext(imm)<<2
//  alu_op      in   3     ALU operation (package encodings)
//  pc_src      in   2     PC source: 0=alu, 1=jump target, 2=A (jr), 3=ALUOut
//  I_or_D      in   1     bus address: 0=PC, 1=ALUOut
//  mem_read    in   1     start a read (one-cycle pulse, accepted only in IDLE)
//  mem_write   in   1     start a write of B (one-cycle pulse, accepted only in IDLE)
//  mem_done    out  1     one-cycle pulse when the bus transaction completes
//  zero        out  1     ALU result == 0 (combinational)
//  ovf         out  1     signed add/sub overflow (combinational)
//  opcode      out  6     IR[31:26]
//  func        out  6     IR[5:0]
//  bus_req     out  1     bus request
//  bus_we      out  1     1 = write
//  bus_addr    out  XLEN  registered byte address
//  bus_wdata   out  XLEN  registered write data
//  bus_rdata   in   XLEN  read data, valid when bus_ack=1
//  bus_ack     in   1     completion; sampled only while bus_req=1
// BEHAVIOUR
//  Reset: PC=RESET_PC; IR, MDR, A, B, ALUOut and all registers = 0; bus FSM=IDLE.
//   Bus outputs and mem_done are 0 during reset.
//  A, B and ALUOut load every cycle. MDR loads only on a read ack.
//  Register 0 reads 0; writes to register 0 are discarded.
//  Regfile write is synchronous; reads are combinational.
//   Same-cycle read and write of the same register returns the old value.
//  PC loads when pc_write | (pc_write_c & (zero ^ branch_ne)).
//  Jump target = {PC[XLEN-1:28], IR[25:0], 2'b00}.
//  ALU arithmetic is mod 2^XLEN. slt compares signed. ovf is 0 for non-add/sub ops.
//  Bus FSM:
//   IDLE -> BUSY on mem_read | mem_write.
//    Latch bus_addr, bus_we and bus_wdata(=B); assert bus_req next cycle.
//   BUSY: hold bus_req and all bus outputs stable until bus_ack.
//    On ack: go to IDLE, pulse mem_done for one cycle, drop bus_req.
//    If it was a read: MDR <= bus_rdata; if IR_write=1 in the ack cycle, IR <= bus_rdata too.
//   Minimum latency: request pulse to mem_done = 2 cycles (ack on the first bus_req cycle).
//  mem_read and mem_write together: the write wins and the read is dropped.
//  Request pulses while BUSY are ignored; no queueing.
//  bus_ack while IDLE is ignored.
//  IR_write outside a read-ack cycle leaves IR unchanged.
//  Reset mid-transaction: bus_req drops asynchronously. No mem_done is issued; a late ack is ignored.
// STRUCTURE
//  Package mc_pkg holds:
//   ALU_ADD=0, SUB=1, AND=2, OR=3, SLT=4, NOR=5, XOR=6, SLL=7;
//   PCSRC_* and ALUB_* encodings; constants FOUR and REG_RA=31; bus state typedef {IDLE, BUSY}.
//  Sub-module mc_regfile #(XLEN, NREG): 2 read ports, 1 write port, r0 hardwired to zero.
//  The ALU, muxes and bus FSM stay inline.
// TESTING
//  Fetch: PC=0, mem_read + I_or_D=0, ack 3 cycles later with rdata=0x8C220004 and IR_write held
//   -> mem_done on the ack cycle +1; IR=0x8C220004; opcode=0x23.
//  Write: ALUOut=0x10, B=0xDEAD, mem_write -> bus_req=1, we=1, addr=0x10, wdata=0xDEAD.
//   Outputs stay stable over 5 wait cycles; one mem_done after ack.
//  Branch: A=B=7, alu_op=SUB, pc_write_c=1, branch_ne=0 -> PC loads. branch_ne=1 -> PC unchanged.
//  r0 and overflow: write 0x5 to r0 -> read 0. 0x7FFFFFFF + 1 -> ovf=1, zero=0.
//  Collision and repeat: mem_read + mem_write together -> bus_we=1.
//   A second request while BUSY -> ignored; exactly one bus_req burst.
//  Reset: rst low during BUSY -> bus_req=0 immediately, PC=RESET_PC.
//   Ack after rst rises -> no mem_done, MDR stays 0.
//  Run all scenarios with XLEN=64 and NREG=16 (jal writes r15).

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the handshake multicycle datapath: ALU ops, mux selects,
// fixed constants and the bus state type.
package mc_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_A      = 2'd2;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd3;

    localparam logic [1:0] ALUB_B      = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam int FOUR   = 4;
    localparam int REG_RA = 31;

    typedef enum logic {IDLE, BUSY} bus_state_t;
endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module mc_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RA   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RA-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [RA-1:0]   rd_addr1,
    input  logic [RA-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2
);
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS-style datapath with a req/ack memory bus, conditional PC
// write and ALU overflow flag.
module mc_datapath_hs
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            pc_write_c,
    input  logic            branch_ne,
    input  logic            IR_write,
    input  logic            reg_dst,
    input  logic            jal_reg,
    input  logic            mem_to_reg,
    input  logic            pc_to_reg,
    input  logic            reg_write,
    input  logic            alu_src_A,
    input  logic [1:0]      alu_src_B,
    input  logic [2:0]      alu_op,
    input  logic [1:0]      pc_src,
    input  logic            I_or_D,
    input  logic            mem_read,
    input  logic            mem_write,
    output logic            mem_done,
    output logic            zero,
    output logic            ovf,
    output logic [5:0]      opcode,
    output logic [5:0]      func,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack
);
    localparam int RA  = $clog2(NREG);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] pc, mdr, a_reg, b_reg, alu_out;
    logic [31:0]     ir;
    bus_state_t      state;

    logic [XLEN-1:0] rd1, rd2, alu_a, alu_b, alu_res, imm_ext, jump_tgt, pc_next, wr_data;
    logic [RA-1:0]   wr_addr;
    logic            pc_load, ack_rd;

    assign opcode   = ir[31:26];
    assign func     = ir[5:0];
    assign imm_ext  = {{(XLEN-16){ir[15]}}, ir[15:0]};
    assign jump_tgt = {pc[XLEN-1:28], ir[25:0], 2'b00};

    // With fewer than 32 registers the 5-bit fields are truncated, so the link register becomes NREG-1.
    assign wr_addr = jal_reg ? RA'(REG_RA) : (reg_dst ? ir[11 +: RA] : ir[16 +: RA]);
    assign wr_data = pc_to_reg ? pc : (mem_to_reg ? mdr : alu_out);

    mc_regfile #(.XLEN(XLEN), .NREG(NREG), .RA(RA)) u_regfile (
        .clk      (clk),
        .rst_n    (rst),
        .we       (reg_write),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (ir[21 +: RA]),
        .rd_addr2 (ir[16 +: RA]),
        .rd_data1 (rd1),
        .rd_data2 (rd2)
    );

    assign alu_a = alu_src_A ? a_reg : pc;

    always_comb begin
        case (alu_src_B)
            ALUB_B:    alu_b = b_reg;
            ALUB_FOUR: alu_b = XLEN'(FOUR);
            ALUB_IMM:  alu_b = imm_ext;
            default:   alu_b = imm_ext << 2;
        endcase
    end

    // sll shifts operand A left by the low bits of operand B.
    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_res = alu_a + alu_b;
                ovf     = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
            end
            ALU_SUB: begin
                alu_res = alu_a - alu_b;
                ovf     = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
            end
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_NOR: alu_res = ~(alu_a | alu_b);
            ALU_XOR: alu_res = alu_a ^ alu_b;
            default: alu_res = alu_a << alu_b[SHW-1:0];
        endcase
    end

    assign zero = (alu_res == '0);

    always_comb begin
        case (pc_src)
            PCSRC_ALU:  pc_next = alu_res;
            PCSRC_JUMP: pc_next = jump_tgt;
            PCSRC_A:    pc_next = a_reg;
            default:    pc_next = alu_out;
        endcase
    end

    assign pc_load = pc_write | (pc_write_c & (zero ^ branch_ne));
    assign ack_rd  = (state == BUSY) && bus_ack && !bus_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            a_reg   <= rd1;
            b_reg   <= rd2;
            alu_out <= alu_res;
            if (pc_load) pc <= pc_next;
            if (ack_rd) begin
                mdr <= bus_rdata;
                if (IR_write) ir <= bus_rdata[31:0];
            end
        end
    end

    // Bus outputs are latched once at request time and held until the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            mem_done  <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        state     <= BUSY;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= I_or_D ? alu_out : pc;
                        bus_wdata <= b_reg;
                    end
                end
                default: begin
                    if (bus_ack) begin
                        state    <= IDLE;
                        bus_req  <= 1'b0;
                        mem_done <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_datapath_hs.sv
// Randomized bench for mc_datapath_hs (XLEN=64, NREG=16) against an
// architectural model of PC, IR, MDR and the register file.
module tb_mc_datapath_hs;
    import mc_pkg::*;

    localparam int          XLEN     = 64;
    localparam int          NREG     = 16;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_0100;

    logic clk = 1'b0;
    logic rst;
    logic pc_write, pc_write_c, branch_ne, IR_write, reg_dst, jal_reg;
    logic mem_to_reg, pc_to_reg, reg_write, alu_src_A, I_or_D, mem_read, mem_write;
    logic [1:0] alu_src_B, pc_src;
    logic [2:0] alu_op;
    logic mem_done, zero, ovf, bus_req, bus_we, bus_ack;
    logic [5:0] opcode, func;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    mc_datapath_hs #(.XLEN(XLEN), .NREG(NREG), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_c(pc_write_c),
        .branch_ne(branch_ne), .IR_write(IR_write), .reg_dst(reg_dst), .jal_reg(jal_reg),
        .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .reg_write(reg_write),
        .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .alu_op(alu_op), .pc_src(pc_src),
        .I_or_D(I_or_D), .mem_read(mem_read), .mem_write(mem_write), .mem_done(mem_done),
        .zero(zero), .ovf(ovf), .opcode(opcode), .func(func), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] m_pc, m_mdr;
    logic [31:0] m_ir;
    logic [63:0] m_regs [NREG];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int ridx(input logic [4:0] f);
        return int'(f) % NREG;
    endfunction

    function automatic logic [63:0] sext16(input logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_ir  = '0;
        m_mdr = '0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    endtask

    task automatic idle_ctrl();
        pc_write = 0; pc_write_c = 0; branch_ne = 0; IR_write = 0; reg_dst = 0;
        jal_reg = 0; mem_to_reg = 0; pc_to_reg = 0; reg_write = 0; alu_src_A = 0;
        alu_src_B = 2'd0; alu_op = 3'd0; pc_src = 2'd0; I_or_D = 0;
        mem_read = 0; mem_write = 0;
    endtask

    // Arithmetic reference: overflow from a sign-extended 65-bit sum.
    task automatic alu_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] res, output logic ov);
        logic [64:0] w;
        ov = 1'b0;
        case (op)
            ALU_ADD: begin w = {a[63], a} + {b[63], b}; res = w[63:0]; ov = w[64] != w[63]; end
            ALU_SUB: begin w = {a[63], a} - {b[63], b}; res = w[63:0]; ov = w[64] != w[63]; end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            ALU_NOR: res = ~(a | b);
            ALU_XOR: res = a ^ b;
            default: res = a << (b % 64);
        endcase
    endtask

    task automatic bus_op(input logic rd, input logic wr, input logic iord, input logic irw,
                          input logic [63:0] rdata, input int wait_n, input logic [63:0] exp_addr,
                          input logic chk_wd, input logic [63:0] exp_wd, input logic extra);
        mem_read = rd; mem_write = wr; I_or_D = iord;
        cyc();
        mem_read = 0; mem_write = 0;
        chk("bus_req_start", bus_req, 1);
        chk("bus_we", bus_we, wr);
        chk("bus_addr", bus_addr, exp_addr);
        if (chk_wd) chk("bus_wdata", bus_wdata, exp_wd);
        for (int i = 0; i < wait_n; i++) begin
            if (extra && i == 0) mem_read = 1;
            cyc();
            mem_read = 0;
            chk("bus_req_hold", bus_req, 1);
            chk("bus_addr_hold", bus_addr, exp_addr);
            chk("bus_we_hold", bus_we, wr);
            chk("early_done", mem_done, 0);
        end
        bus_ack = 1; bus_rdata = rdata; IR_write = irw;
        cyc();
        bus_ack = 0; IR_write = 0;
        chk("mem_done_pulse", mem_done, 1);
        chk("bus_req_drop", bus_req, 0);
        cyc();
        chk("mem_done_single", mem_done, 0);
        chk("bus_req_idle", bus_req, 0);
        if (rd && !wr) begin
            m_mdr = rdata;
            if (irw) m_ir = rdata[31:0];
        end
    endtask

    task automatic fetch(input logic [31:0] instr);
        bus_op(1, 0, 0, 1, {$urandom(), instr}, $urandom_range(0, 3), m_pc, 0, '0, 0);
        chk("opcode", opcode, instr[31:26]);
        chk("func", func, instr[5:0]);
    endtask

    task automatic set_ir(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        fetch({6'($urandom()), rs, rt, imm});
    endtask

    task automatic write_reg(input logic [4:0] f, input logic [63:0] v);
        logic use_rd;
        logic [4:0] other;
        use_rd = 1'($urandom_range(0, 1));
        other  = 5'($urandom());
        fetch({6'h23, 5'($urandom()), use_rd ? other : f, use_rd ? f : other, 11'($urandom())});
        bus_op(1, 0, 0, 0, v, $urandom_range(0, 2), m_pc, 0, '0, 0);
        chk("ir_kept", opcode, m_ir[31:26]);
        reg_dst = use_rd; mem_to_reg = 1; reg_write = 1;
        cyc();
        idle_ctrl();
        cyc();
        if (ridx(f) != 0) m_regs[ridx(f)] = v;
    endtask

    task automatic alu_exec(input logic [2:0] op, input logic sa, input logic [1:0] sb, input int wait_n);
        logic [63:0] a, b, res, bv;
        logic ov;
        bv = m_regs[ridx(m_ir[20:16])];
        a  = sa ? m_regs[ridx(m_ir[25:21])] : m_pc;
        case (sb)
            2'd0:    b = bv;
            2'd1:    b = 64'd4;
            2'd2:    b = sext16(m_ir[15:0]);
            default: b = sext16(m_ir[15:0]) * 4;
        endcase
        alu_ref(op, a, b, res, ov);
        alu_src_A = sa; alu_src_B = sb; alu_op = op;
        #1;
        chk("zero", zero, (res == 64'd0));
        chk("ovf", ovf, ov);
        cyc();
        bus_op(0, 1, 1, 0, '0, wait_n, res, 1, bv, 0);
        idle_ctrl();
    endtask

    task automatic branch(input logic ne);
        logic eq;
        eq = m_regs[ridx(m_ir[25:21])] == m_regs[ridx(m_ir[20:16])];
        alu_src_A = 1; alu_src_B = ALUB_B; alu_op = ALU_SUB;
        pc_write_c = 1; branch_ne = ne; pc_src = PCSRC_JUMP;
        #1;
        chk("branch_zero", zero, eq);
        cyc();
        idle_ctrl();
        if (eq ^ ne) m_pc = {m_pc[63:28], m_ir[25:0], 2'b00};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        idle_ctrl();
        bus_ack = 0; bus_rdata = '0; rst = 0;
        model_reset();
        cyc(); cyc();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_mem_done", mem_done, 0);
        chk("rst_opcode", opcode, 0);
        rst = 1;
        cyc();

        // Stray ack in IDLE with IR_write high must do nothing.
        bus_ack = 1; IR_write = 1; bus_rdata = rnd64();
        cyc();
        bus_ack = 0; IR_write = 0;
        chk("idle_ack_done", mem_done, 0);
        chk("idle_ack_req", bus_req, 0);
        chk("idle_ack_ir", opcode, m_ir[31:26]);
        cyc();

        bus_op(1, 0, 0, 1, 64'h0000_0000_8C22_0004, 3, m_pc, 0, '0, 0);
        chk("fetch_opcode", opcode, 6'h23);

        write_reg(5'd1, 64'h10);
        write_reg(5'd2, 64'hDEAD);
        set_ir(5'd1, 5'd2, 16'h0000);
        alu_exec(ALU_ADD, 1, ALUB_IMM, 5);

        write_reg(5'd1, 64'd7);
        write_reg(5'd2, 64'd7);
        set_ir(5'd1, 5'd2, 16'($urandom()));
        branch(0);
        set_ir(5'd1, 5'd2, 16'($urandom()));
        branch(1);
        set_ir(5'd1, 5'd2, 16'($urandom()));

        write_reg(5'd0, 64'h5);
        write_reg(5'd16, 64'h5);
        set_ir(5'd0, 5'd16, 16'h0000);
        alu_exec(ALU_OR, 1, ALUB_B, 0);

        write_reg(5'd3, 64'h7FFF_FFFF_FFFF_FFFF);
        set_ir(5'd3, 5'd0, 16'h0001);
        alu_exec(ALU_ADD, 1, ALUB_IMM, 1);
        write_reg(5'd4, 64'h8000_0000_0000_0000);
        set_ir(5'd4, 5'd0, 16'h0001);
        alu_exec(ALU_SUB, 1, ALUB_IMM, 0);

        // Read+write collision: write wins, MDR untouched, repeat request ignored.
        bus_op(1, 1, 0, 0, rnd64(), 2, m_pc, 1, m_regs[ridx(m_ir[20:16])], 1);
        jal_reg = 1; mem_to_reg = 1; reg_write = 1;
        cyc();
        idle_ctrl();
        cyc();
        m_regs[NREG-1] = m_mdr;
        set_ir(5'd15, 5'd15, 16'h0000);
        alu_exec(ALU_OR, 1, ALUB_B, 1);

        jal_reg = 1; pc_to_reg = 1; mem_to_reg = 1; reg_write = 1;
        cyc();
        idle_ctrl();
        cyc();
        m_regs[NREG-1] = m_pc;
        set_ir(5'd31, 5'd15, 16'($urandom()));
        alu_exec(ALU_XOR, 1, ALUB_IMM_SH, 0);

        alu_src_B = ALUB_FOUR; alu_op = ALU_ADD; pc_src = PCSRC_ALU; pc_write = 1;
        cyc();
        idle_ctrl();
        m_pc = m_pc + 64'd4;
        write_reg(5'd5, rnd64());
        set_ir(5'd5, 5'd0, 16'h0000);
        pc_src = PCSRC_A; pc_write = 1;
        cyc();
        idle_ctrl();
        m_pc = m_regs[5];
        set_ir(5'd0, 5'd0, 16'h0000);

        for (int i = 0; i < 24; i++) begin
            logic [4:0] fa, fb;
            logic [63:0] va;
            fa = 5'($urandom());
            fb = 5'($urandom());
            va = (i % 5 == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : rnd64();
            write_reg(fa, va);
            write_reg(fb, (i % 3 == 0) ? va : rnd64());
            set_ir(fa, fb, 16'($urandom()));
            if (i % 4 == 3) begin
                branch(1'($urandom_range(0, 1)));
                set_ir(fa, fb, 16'($urandom()));
            end else begin
                alu_exec(3'($urandom()), 1'($urandom_range(0, 1)), 2'($urandom()), $urandom_range(0, 3));
            end
        end

        // Reset in the middle of a read; a late ack must not complete it.
        mem_read = 1; I_or_D = 0;
        cyc();
        mem_read = 0;
        chk("busy_before_rst", bus_req, 1);
        #2 rst = 0;
        #1;
        chk("rst_async_req", bus_req, 0);
        chk("rst_async_done", mem_done, 0);
        model_reset();
        cyc();
        rst = 1;
        cyc();
        bus_ack = 1; bus_rdata = 64'hA5A5_5A5A_1234_5678;
        cyc();
        bus_ack = 0;
        chk("late_ack_done", mem_done, 0);
        cyc();
        chk("late_ack_done2", mem_done, 0);
        chk("late_ack_req", bus_req, 0);
        jal_reg = 1; mem_to_reg = 1; reg_write = 1;
        cyc();
        idle_ctrl();
        cyc();
        m_regs[NREG-1] = m_mdr;
        set_ir(5'd15, 5'd15, 16'h0000);
        alu_exec(ALU_ADD, 1, ALUB_B, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
